// File: rtl/if_id_pkg.sv
// Shared definitions for the elastic IF/ID stage: FSM encoding, NOP default,
// RV32 field positions and the field-slicing helper.
package if_id_pkg;

    localparam int OPCODE_W = 7;
    localparam int RD_W     = 5;
    localparam int FUNC3_W  = 3;
    localparam int RS_W     = 5;
    localparam int FUNC7_W  = 7;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNC3_LSB  = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNC7_LSB  = 25;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    // Encoding doubles as the number of held entries.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        ONE   = ST_ONE,
        FULL  = ST_FULL
    } state_e;

    typedef struct packed {
        logic [FUNC7_W-1:0]  func7;
        logic [RS_W-1:0]     rs2;
        logic [RS_W-1:0]     rs1;
        logic [FUNC3_W-1:0]  func3;
        logic [RD_W-1:0]     rd;
        logic [OPCODE_W-1:0] opcode;
    } fields_t;

    function automatic fields_t slice_fields(input logic [31:0] instr);
        fields_t f;
        f.opcode = instr[OPCODE_LSB +: OPCODE_W];
        f.rd     = instr[RD_LSB     +: RD_W];
        f.func3  = instr[FUNC3_LSB  +: FUNC3_W];
        f.rs1    = instr[RS1_LSB    +: RS_W];
        f.rs2    = instr[RS2_LSB    +: RS_W];
        f.func7  = instr[FUNC7_LSB  +: FUNC7_W];
        return f;
    endfunction

endpackage

// File: rtl/if_id_slot.sv
// One payload entry of the IF/ID skid buffer: instruction, PCs and the decoded
// fields, all registered together so the fields always match the instruction.
module if_id_slot
    import if_id_pkg::*;
#(
    parameter int                  NB_INSTR  = 32,
    parameter int                  NB_PC     = 32,
    parameter logic [NB_INSTR-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                load,
    input  logic                load_nop,
    input  logic [NB_INSTR-1:0] d_instr,
    input  logic [NB_PC-1:0]    d_pc,
    input  logic [NB_PC-1:0]    d_pc_next,
    input  fields_t             d_fields,
    output logic [NB_INSTR-1:0] q_instr,
    output logic [NB_PC-1:0]    q_pc,
    output logic [NB_PC-1:0]    q_pc_next,
    output fields_t             q_fields
);

    localparam fields_t NOP_FIELDS = slice_fields(NOP_INSTR);

    logic [NB_INSTR-1:0] instr_reg;
    logic [NB_PC-1:0]    pc_reg;
    logic [NB_PC-1:0]    pc_next_reg;
    fields_t             fields_reg;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            instr_reg   <= NOP_INSTR;
            pc_reg      <= '0;
            pc_next_reg <= '0;
            fields_reg  <= NOP_FIELDS;
        end else if (load_nop) begin
            instr_reg   <= NOP_INSTR;
            pc_reg      <= '0;
            pc_next_reg <= '0;
            fields_reg  <= NOP_FIELDS;
        end else if (load) begin
            instr_reg   <= d_instr;
            pc_reg      <= d_pc;
            pc_next_reg <= d_pc_next;
            fields_reg  <= d_fields;
        end
    end

    assign q_instr   = instr_reg;
    assign q_pc      = pc_reg;
    assign q_pc_next = pc_next_reg;
    assign q_fields  = fields_reg;

endmodule

// File: rtl/if_id_skid_reg.sv
// Elastic IF/ID stage: 2-entry skid buffer (head + skid slot) with a registered
// ready, single-cycle flush and a saturating back-pressure stall counter.
module if_id_skid_reg
    import if_id_pkg::*;
#(
    parameter int                  NB_INSTR  = 32,
    parameter int                  NB_PC     = 32,
    parameter int                  NB_CNT    = 16,
    parameter logic [NB_INSTR-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [NB_INSTR-1:0] i_instr,
    input  logic [NB_PC-1:0]    i_pc,
    input  logic [NB_PC-1:0]    i_pc_next,
    input  logic                i_flush,
    input  logic                i_cnt_clr,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [NB_PC-1:0]    o_pc,
    output logic [NB_PC-1:0]    o_pc_next,
    output logic [NB_INSTR-1:0] o_instr,
    output logic [6:0]          o_opcode,
    output logic [4:0]          o_rd_addr,
    output logic [2:0]          o_func3,
    output logic [4:0]          o_rs1_addr,
    output logic [4:0]          o_rs2_addr,
    output logic [6:0]          o_func7,
    output logic [1:0]          o_occupancy,
    output logic [NB_CNT-1:0]   o_stall_cnt
);

    localparam int HEAD = 0;
    localparam int SKID = 1;

    state_e              state_reg, state_next;
    logic                ready_reg;
    logic [NB_CNT-1:0]   cnt_reg;

    logic                in_xfer, out_xfer;
    logic                head_load, head_nop, head_from_skid, skid_load;
    fields_t             in_fields;

    logic                slot_load     [2];
    logic                slot_nop      [2];
    logic [NB_INSTR-1:0] slot_d_instr  [2];
    logic [NB_PC-1:0]    slot_d_pc     [2];
    logic [NB_PC-1:0]    slot_d_pc_nx  [2];
    fields_t             slot_d_fields [2];
    logic [NB_INSTR-1:0] slot_q_instr  [2];
    logic [NB_PC-1:0]    slot_q_pc     [2];
    logic [NB_PC-1:0]    slot_q_pc_nx  [2];
    fields_t             slot_q_fields [2];

    assign o_valid  = (state_reg != EMPTY);
    assign o_ready  = ready_reg;
    assign in_xfer  = i_valid & ready_reg;
    assign out_xfer = o_valid & i_ready;
    assign in_fields = slice_fields(i_instr);

    always_comb begin
        state_next     = state_reg;
        head_load      = 1'b0;
        head_nop       = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (i_flush) begin
            state_next = EMPTY;
            head_nop   = 1'b1;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_xfer) begin
                        head_load  = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_load = 1'b1;
                    end else if (in_xfer) begin
                        skid_load  = 1'b1;
                        state_next = FULL;
                    end else if (out_xfer) begin
                        head_nop   = 1'b1;
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: begin
                    head_nop   = 1'b1;
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // Ready is derived from the next state so it never depends on i_ready combinationally.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= EMPTY;
            ready_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next != FULL);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg <= '0;
        end else if (i_cnt_clr) begin
            cnt_reg <= '0;
        end else if (o_valid && !i_ready && (cnt_reg != {NB_CNT{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign slot_load[HEAD]     = head_load;
    assign slot_nop[HEAD]      = head_nop;
    assign slot_d_instr[HEAD]  = head_from_skid ? slot_q_instr[SKID]  : i_instr;
    assign slot_d_pc[HEAD]     = head_from_skid ? slot_q_pc[SKID]     : i_pc;
    assign slot_d_pc_nx[HEAD]  = head_from_skid ? slot_q_pc_nx[SKID]  : i_pc_next;
    assign slot_d_fields[HEAD] = head_from_skid ? slot_q_fields[SKID] : in_fields;

    assign slot_load[SKID]     = skid_load;
    assign slot_nop[SKID]      = 1'b0;
    assign slot_d_instr[SKID]  = i_instr;
    assign slot_d_pc[SKID]     = i_pc;
    assign slot_d_pc_nx[SKID]  = i_pc_next;
    assign slot_d_fields[SKID] = in_fields;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            if_id_slot #(
                .NB_INSTR  (NB_INSTR),
                .NB_PC     (NB_PC),
                .NOP_INSTR (NOP_INSTR)
            ) u_slot (
                .clk       (clk),
                .i_rst_n   (i_rst_n),
                .load      (slot_load[gi]),
                .load_nop  (slot_nop[gi]),
                .d_instr   (slot_d_instr[gi]),
                .d_pc      (slot_d_pc[gi]),
                .d_pc_next (slot_d_pc_nx[gi]),
                .d_fields  (slot_d_fields[gi]),
                .q_instr   (slot_q_instr[gi]),
                .q_pc      (slot_q_pc[gi]),
                .q_pc_next (slot_q_pc_nx[gi]),
                .q_fields  (slot_q_fields[gi])
            );
        end
    endgenerate

    assign o_instr     = slot_q_instr[HEAD];
    assign o_pc        = slot_q_pc[HEAD];
    assign o_pc_next   = slot_q_pc_nx[HEAD];
    assign o_opcode    = slot_q_fields[HEAD].opcode;
    assign o_rd_addr   = slot_q_fields[HEAD].rd;
    assign o_func3     = slot_q_fields[HEAD].func3;
    assign o_rs1_addr  = slot_q_fields[HEAD].rs1;
    assign o_rs2_addr  = slot_q_fields[HEAD].rs2;
    assign o_func7     = slot_q_fields[HEAD].func7;
    assign o_occupancy = state_reg;
    assign o_stall_cnt = cnt_reg;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: queue-based reference model, directed
// cases with literal expectations, then a randomized handshake/flush run.
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_cnt_clr = 1'b0;
    logic [31:0] i_instr = '0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_pc_next = '0;

    logic        a_ready, a_valid;
    logic [31:0] a_pc, a_pc_next, a_instr;
    logic [6:0]  a_opcode, a_func7;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_func3;
    logic [1:0]  a_occ;
    logic [15:0] a_cnt;

    logic        b_ready, b_valid;
    logic [31:0] b_pc, b_pc_next, b_instr;
    logic [6:0]  b_opcode, b_func7;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_func3;
    logic [1:0]  b_occ;
    logic [1:0]  b_cnt;

    always #5 clk = ~clk;

    if_id_skid_reg #(.NB_INSTR(32), .NB_PC(32), .NB_CNT(16)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(a_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_pc_next(i_pc_next), .i_flush(i_flush),
        .i_cnt_clr(i_cnt_clr), .o_valid(a_valid), .i_ready(i_ready), .o_pc(a_pc),
        .o_pc_next(a_pc_next), .o_instr(a_instr), .o_opcode(a_opcode), .o_rd_addr(a_rd),
        .o_func3(a_func3), .o_rs1_addr(a_rs1), .o_rs2_addr(a_rs2), .o_func7(a_func7),
        .o_occupancy(a_occ), .o_stall_cnt(a_cnt)
    );

    if_id_skid_reg #(.NB_INSTR(32), .NB_PC(32), .NB_CNT(2)) dut_small (
        .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(b_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_pc_next(i_pc_next), .i_flush(i_flush),
        .i_cnt_clr(i_cnt_clr), .o_valid(b_valid), .i_ready(i_ready), .o_pc(b_pc),
        .o_pc_next(b_pc_next), .o_instr(b_instr), .o_opcode(b_opcode), .o_rd_addr(b_rd),
        .o_func3(b_func3), .o_rs1_addr(b_rs1), .o_rs2_addr(b_rs2), .o_func7(b_func7),
        .o_occupancy(b_occ), .o_stall_cnt(b_cnt)
    );

    int n_checks = 0;
    int n_err = 0;

    // Reference model: FIFO of held entries plus two saturating stall counts.
    logic [31:0] m_instr[$];
    logic [31:0] m_pc[$];
    logic [31:0] m_pcn[$];
    int          m_cnt = 0;
    int          m_cnt2 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_dut(input string tag, input logic v, input logic r, input logic [1:0] occ,
                           input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pcn,
                           input logic [6:0] opc, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                           input logic [63:0] cnt, input logic [63:0] ecnt);
        int          sz;
        logic [31:0] e_instr, e_pc, e_pcn;
        sz      = m_instr.size();
        e_instr = (sz > 0) ? m_instr[0] : 32'h0000_0013;
        e_pc    = (sz > 0) ? m_pc[0]    : 32'h0;
        e_pcn   = (sz > 0) ? m_pcn[0]   : 32'h0;
        chk({tag, "_valid"}, v, (sz > 0));
        chk({tag, "_ready"}, r, (sz < 2));
        chk({tag, "_occupancy"}, occ, sz);
        chk({tag, "_instr"}, ins, e_instr);
        chk({tag, "_pc"}, pc, e_pc);
        chk({tag, "_pc_next"}, pcn, e_pcn);
        chk({tag, "_opcode"}, opc, e_instr[6:0]);
        chk({tag, "_rd"}, rd, e_instr[11:7]);
        chk({tag, "_func3"}, f3, e_instr[14:12]);
        chk({tag, "_rs1"}, rs1, e_instr[19:15]);
        chk({tag, "_rs2"}, rs2, e_instr[24:20]);
        chk({tag, "_func7"}, f7, e_instr[31:25]);
        chk({tag, "_stall_cnt"}, cnt, ecnt);
    endtask

    task automatic cmp_all();
        cmp_dut("dut", a_valid, a_ready, a_occ, a_instr, a_pc, a_pc_next, a_opcode, a_rd,
                a_func3, a_rs1, a_rs2, a_func7, 64'(a_cnt), 64'(m_cnt));
        cmp_dut("small", b_valid, b_ready, b_occ, b_instr, b_pc, b_pc_next, b_opcode, b_rd,
                b_func3, b_rs1, b_rs2, b_func7, 64'(b_cnt), 64'(m_cnt2));
    endtask

    task automatic model_step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                              input logic rdy, input logic fl, input logic clr);
        int sz;
        sz = m_instr.size();
        if (clr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (sz > 0 && !rdy) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (sz > 0 && rdy)
            $display("deliver pc=%08h instr=%08h%s", m_pc[0], m_instr[0], fl ? " (flush cycle)" : "");
        if (fl) begin
            m_instr.delete();
            m_pc.delete();
            m_pcn.delete();
        end else begin
            if (sz > 0 && rdy) begin
                void'(m_instr.pop_front());
                void'(m_pc.pop_front());
                void'(m_pcn.pop_front());
            end
            if (v && sz < 2) begin
                m_instr.push_back(ins);
                m_pc.push_back(pc);
                m_pcn.push_back(pc + 32'd4);
            end
        end
    endtask

    // Called at a falling edge; drives one cycle of inputs and checks after the next rising edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, input logic clr);
        logic ra, rb;
        ra = a_ready;
        rb = b_ready;
        i_valid   = v;
        i_instr   = ins;
        i_pc      = pc;
        i_pc_next = pc + 32'd4;
        i_ready   = rdy;
        i_flush   = fl;
        i_cnt_clr = clr;
        #1;
        chk("dut_ready_stable", a_ready, ra);
        chk("small_ready_stable", b_ready, rb);
        model_step(v, ins, pc, rdy, fl, clr);
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    localparam logic [31:0] A = 32'h0020_8033;
    localparam logic [31:0] B = 32'h4020_8033;
    localparam logic [31:0] C = 32'h0020_c0b3;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        #1;
        cmp_all();
        chk("reset_valid", a_valid, 0);
        chk("reset_ready", a_ready, 1);
        chk("reset_instr", a_instr, 32'h13);
        chk("reset_cnt", a_cnt, 0);
        @(negedge clk);

        // First instruction and a back-to-back stream
        step(1, 32'h0050_0093, 32'h100, 1, 0, 0);
        chk("t1_valid", a_valid, 1);
        chk("t1_rd", a_rd, 1);
        chk("t1_opcode", a_opcode, 7'h13);
        chk("t1_pc", a_pc, 32'h100);
        chk("t1_rs2", a_rs2, 5);
        for (int k = 1; k < 4; k++) begin
            step(1, 32'h0000_0113 + 32'(k << 20), 32'h100 + 32'(4 * k), 1, 0, 0);
            chk("stream_occ", a_occ, 1);
            chk("stream_pc", a_pc, 32'h100 + 32'(4 * k));
        end
        step(0, 32'h0, 32'h0, 1, 0, 0);
        chk("drain_valid", a_valid, 0);

        // Back-pressure fill and in-order drain
        step(1, A, 32'h200, 0, 0, 0);
        chk("bp_occ1", a_occ, 1);
        step(1, B, 32'h204, 0, 0, 0);
        chk("bp_occ2", a_occ, 2);
        chk("bp_ready_low", a_ready, 0);
        step(1, C, 32'h208, 0, 0, 0);
        chk("bp_hold_instr", a_instr, A);
        step(1, C, 32'h208, 1, 0, 0);
        chk("bp_head_b", a_instr, B);
        chk("bp_ready_high", a_ready, 1);
        step(1, C, 32'h208, 1, 0, 0);
        chk("bp_head_c", a_instr, C);
        chk("bp_pc_c", a_pc, 32'h208);
        step(0, 32'h0, 32'h0, 1, 0, 0);
        chk("bp_empty", a_occ, 0);

        // Flush while full drops both entries and the offered input
        step(1, A, 32'h300, 0, 0, 0);
        step(1, B, 32'h304, 0, 0, 0);
        step(1, 32'h00a0_0513, 32'h308, 0, 1, 0);
        chk("fl_valid", a_valid, 0);
        chk("fl_instr", a_instr, 32'h13);
        chk("fl_pc", a_pc, 0);
        chk("fl_ready", a_ready, 1);
        step(0, 32'h0, 32'h0, 1, 0, 0);
        chk("fl_after_valid", a_valid, 0);

        // Stall counter counts, saturates in the narrow instance, and clears
        step(1, 32'h00f0_0793, 32'h400, 0, 0, 1);
        chk("st_clr", a_cnt, 0);
        repeat (5) step(0, 32'h0, 32'h0, 0, 0, 0);
        chk("st_five", a_cnt, 5);
        chk("st_sat_small", b_cnt, 3);
        repeat (5) step(0, 32'h0, 32'h0, 0, 0, 0);
        chk("st_ten", a_cnt, 10);
        chk("st_sat_small10", b_cnt, 3);
        step(0, 32'h0, 32'h0, 0, 0, 1);
        chk("st_clear", a_cnt, 0);
        chk("st_clear_small", b_cnt, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0);

        // Asynchronous reset between edges while full
        step(1, A, 32'h500, 0, 0, 0);
        step(1, B, 32'h504, 0, 0, 0);
        i_valid = 1'b1;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("ar_valid", a_valid, 0);
        chk("ar_ready", a_ready, 1);
        chk("ar_occ", a_occ, 0);
        chk("ar_instr", a_instr, 32'h13);
        chk("ar_pc", a_pc, 0);
        chk("ar_cnt", a_cnt, 0);
        m_instr.delete();
        m_pc.delete();
        m_pcn.delete();
        m_cnt  = 0;
        m_cnt2 = 0;
        @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        step(0, 32'h0, 32'h0, 1, 0, 0);

        // Randomized handshakes, flushes and counter clears
        for (int n = 0; n < 10000; n++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom & 32'hffff_fffc,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 63) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
